// File: rtl/cacheline_adapter_if.sv
// Purpose: bundles the d_cache pmem line port and the 64-bit burst memory port.
// Latency: none, wires only.
// Backpressure: the memory side stalls the adapter by holding burst_resp_i low.
//
// Ports (slave = adapter view):
//   line_address_i, line_i, line_read_i, line_write_i  line request from cache
//   line_o, line_resp_o                                line result to cache
//   burst_address_o, burst_o, burst_read_o, burst_write_o  burst request to memory
//   burst_i, burst_resp_i                              beat data/ack from memory
interface cacheline_adapter_if #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
);
    logic [31:0]        line_address_i;
    logic [s_line-1:0]  line_i;
    logic               line_read_i;
    logic               line_write_i;
    logic [s_line-1:0]  line_o;
    logic               line_resp_o;

    logic [31:0]        burst_address_o;
    logic [s_burst-1:0] burst_o;
    logic               burst_read_o;
    logic               burst_write_o;
    logic [s_burst-1:0] burst_i;
    logic               burst_resp_i;

    modport slave (
        input  line_address_i, line_i, line_read_i, line_write_i,
        input  burst_i, burst_resp_i,
        output line_o, line_resp_o,
        output burst_address_o, burst_o, burst_read_o, burst_write_o
    );

    modport master (
        output line_address_i, line_i, line_read_i, line_write_i,
        output burst_i, burst_resp_i,
        input  line_o, line_resp_o,
        input  burst_address_o, burst_o, burst_read_o, burst_write_o
    );
endinterface

// File: rtl/cacheline_adapter.sv
// Purpose: turns one 256-bit cache line read/write into a fixed 4-beat 64-bit memory burst.
// Latency: request seen in IDLE at t, beats from t+1, one-cycle line_resp_o after the last ack.
// Backpressure: burst_resp_i low stalls the burst; state, beat counter and burst_o are held.
//
// Ports: clk (rising edge), rst (async, active-low), bus (cacheline_adapter_if.slave):
//   line side  - line_address_i/line_i/line_read_i/line_write_i in, line_o/line_resp_o out
//   burst side - burst_address_o/burst_o/burst_read_o/burst_write_o out, burst_i/burst_resp_i in
module cacheline_adapter #(
    parameter int s_offset  = 5,
    parameter int s_line    = 8 * (2 ** s_offset),
    parameter int s_burst   = 64,
    parameter int num_beats = s_line / s_burst
) (
    input  logic                 clk,
    input  logic                 rst,
    cacheline_adapter_if.slave   bus
);
    localparam int cnt_w   = $clog2(num_beats);
    localparam int lsb_w   = $clog2(s_line);
    localparam int burst_w = $clog2(s_burst);
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(num_beats - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [cnt_w-1:0]    cnt;
    logic [31:0]         addr_q;
    logic [s_line-1:0]   wbuf_q;
    logic [s_line-1:0]   line_q;
    logic [lsb_w-1:0]    beat_lsb;
    logic                in_burst;
    logic                beat_acc;
    logic                start_wr;
    logic                start_rd;

    // Beat n occupies bits [n*s_burst +: s_burst]; beat 0 is the low word.
    assign beat_lsb = {cnt, {burst_w{1'b0}}};
    assign in_burst = (state == READ) || (state == WRITE);
    // Acks outside a burst (IDLE/DONE) are ignored.
    assign beat_acc = in_burst && bus.burst_resp_i;
    // Write has priority; a concurrent read stays pending and is taken later.
    assign start_wr = (state == IDLE) && bus.line_write_i;
    assign start_rd = (state == IDLE) && !bus.line_write_i && bus.line_read_i;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.line_write_i) begin
                    state_nxt = WRITE;
                end else if (bus.line_read_i) begin
                    state_nxt = READ;
                end
            end
            READ, WRITE: begin
                if (bus.burst_resp_i && (cnt == last_cnt)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latched address/write line, beat counter, read line assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            addr_q <= '0;
            wbuf_q <= '0;
            line_q <= '0;
        end else begin
            if (start_wr || start_rd) begin
                addr_q <= {bus.line_address_i[31:s_offset], {s_offset{1'b0}}};
                cnt    <= '0;
            end
            if (start_wr) begin
                wbuf_q <= bus.line_i;
            end
            if (beat_acc) begin
                // Counter wraps to 0 on the last beat.
                cnt <= cnt + 1'b1;
                if (state == READ) begin
                    line_q[beat_lsb +: s_burst] <= bus.burst_i;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        bus.burst_read_o  = 1'b0;
        bus.burst_write_o = 1'b0;
        bus.line_resp_o   = 1'b0;
        unique case (state)
            READ:    bus.burst_read_o  = 1'b1;
            WRITE:   bus.burst_write_o = 1'b1;
            DONE:    bus.line_resp_o   = 1'b1;
            default: ;
        endcase
    end

    assign bus.burst_address_o = addr_q;
    assign bus.burst_o         = wbuf_q[beat_lsb +: s_burst];
    assign bus.line_o          = line_q;
endmodule

// File: tb/tb_cacheline_adapter.sv
module tb_cacheline_adapter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_adapter_if #(.s_line(256), .s_burst(64)) bus();

    cacheline_adapter #(.s_offset(5), .s_line(256), .s_burst(64), .num_beats(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [255:0] model_line;   // what line_o must hold between transactions

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;      // write line, or memory contents for a read
        int           stall;     // idle cycles memory inserts before each ack
        logic [31:0]  exp_addr;
        logic [255:0] exp_line;  // beats seen on burst_o, or final line_o
        int           exp_lat;   // request cycle to line_resp_o cycle
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: 4 beats, each taking (stall+1) cycles, plus the response cycle.
    function automatic int model_lat(input int stall);
        return 4 * (stall + 1) + 1;
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    // Quiet cycles: no request, random spurious acks; nothing may move.
    task automatic idle(input int n, input string name);
        bit bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.line_read_i  = 1'b0;
            bus.line_write_i = 1'b0;
            bus.burst_resp_i = 1'($urandom_range(0, 1));
            bus.burst_i      = {$urandom, $urandom};
            #4;
            if (bus.line_resp_o || bus.burst_read_o || bus.burst_write_o) bad = 1'b1;
            if (bus.line_o !== model_line) bad = 1'b1;
        end
        if (n > 0) chk(name, 256'(bad), 256'(0));
    endtask

    // One line transaction against a reactive burst memory.
    task automatic do_txn(input string tag, input bit wr, input bit rd,
                          input logic [31:0] addr, input logic [255:0] data,
                          input int stall, input bit scramble,
                          input logic [31:0] exp_addr, input logic [255:0] exp_line,
                          input int exp_lat);
        int cyc = 0;
        int k = 0;
        int st = stall;
        int lat = -1;
        int active = 0;
        bit wrong_dir = 1'b0;
        bit addr_moved = 1'b0;
        bit hold_bad = 1'b0;
        bit seen_a = 1'b0;
        logic [255:0] got_w = '0;
        logic [31:0]  got_a = '0;

        @(posedge clk); #1;
        bus.line_write_i   = wr;
        bus.line_read_i    = rd | ~wr;
        bus.line_address_i = addr;
        bus.line_i         = wr ? data : rand256();
        bus.burst_resp_i   = 1'b0;
        bus.burst_i        = {$urandom, $urandom};
        while (lat < 0 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (scramble) begin
                bus.line_address_i = $urandom;
                bus.line_i         = rand256();
            end
            if (bus.burst_read_o || bus.burst_write_o) begin
                active++;
                if (wr ? bus.burst_read_o : bus.burst_write_o) wrong_dir = 1'b1;
                if (!seen_a) begin
                    got_a  = bus.burst_address_o;
                    seen_a = 1'b1;
                end else if (bus.burst_address_o !== got_a) begin
                    addr_moved = 1'b1;
                end
                if (wr && k < 4 && bus.burst_o !== data[k*64 +: 64]) hold_bad = 1'b1;
                if (st == 0 && k < 4) begin
                    bus.burst_resp_i = 1'b1;
                    bus.burst_i      = wr ? {$urandom, $urandom} : data[k*64 +: 64];
                    if (wr) got_w[k*64 +: 64] = bus.burst_o;
                    k++;
                    st = stall;
                end else begin
                    bus.burst_resp_i = 1'b0;
                    bus.burst_i      = {$urandom, $urandom};
                    if (st > 0) st--;
                end
            end else begin
                bus.burst_resp_i = 1'($urandom_range(0, 1));
                bus.burst_i      = {$urandom, $urandom};
            end
            #4;
            if (bus.line_resp_o) lat = cyc;
        end
        if (lat < 0) $display("FAIL %s timeout waiting for line_resp_o got=none exp=pulse", tag);
        chk({tag, " latency"}, 256'(lat), 256'(exp_lat));
        chk({tag, " burst_address"}, 256'(got_a), 256'(exp_addr));
        chk({tag, " bus {wrong_dir,addr_moved,active_ok}"},
            256'({wrong_dir, addr_moved, active == exp_lat - 1}), 256'(3'b001));
        if (wr) begin
            chk({tag, " write beats"}, got_w, exp_line);
            chk({tag, " burst_o held"}, 256'(hold_bad), 256'(0));
            chk({tag, " line_o kept"}, bus.line_o, model_line);
        end else begin
            chk({tag, " read line"}, bus.line_o, exp_line);
            model_line = exp_line;
        end
    endtask

    initial begin
        logic [255:0] l0, l1;
        logic [31:0]  a0;
        bit           w;
        int           s;

        tbl[0] = '{1'b0, 32'h0000_1234,
                   {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                   0, 32'h0000_1220,
                   {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 5};
        tbl[1] = '{1'b1, 32'h8000_0040,
                   {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                    64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A},
                   2, 32'h8000_0040,
                   {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                    64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A}, 13};
        tbl[2] = '{1'b0, 32'hFFFF_FFFF,
                   {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                    64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0},
                   1, 32'hFFFF_FFE0,
                   {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                    64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0}, 9};
        tbl[3] = '{1'b1, 32'h0000_001F,
                   {64'h1, 64'h2, 64'h3, 64'h4},
                   0, 32'h0000_0000,
                   {64'h1, 64'h2, 64'h3, 64'h4}, 5};

        rst = 1'b0;
        bus.line_address_i = '0;
        bus.line_i         = '0;
        bus.line_read_i    = 1'b0;
        bus.line_write_i   = 1'b0;
        bus.burst_i        = '0;
        bus.burst_resp_i   = 1'b0;
        model_line         = '0;

        repeat (2) @(posedge clk);
        #5;
        chk("reset line_o", bus.line_o, 256'(0));
        chk("reset {resp,rd,wr}", 256'({bus.line_resp_o, bus.burst_read_o, bus.burst_write_o}), 256'(0));
        chk("reset burst_o", 256'(bus.burst_o), 256'(0));
        chk("reset burst_address", 256'(bus.burst_address_o), 256'(0));
        rst = 1'b1;

        idle(3, "spurious ack in idle");

        // Directed vectors
        for (int i = 0; i < 4; i++) begin
            do_txn($sformatf("vec%0d", i), tbl[i].wr, 1'b0, tbl[i].addr, tbl[i].data,
                   tbl[i].stall, 1'b0, tbl[i].exp_addr, tbl[i].exp_line, tbl[i].exp_lat);
            idle(2, $sformatf("vec%0d single resp", i));
        end

        // Read and write together: write first, pending read follows immediately.
        l0 = rand256();
        l1 = rand256();
        do_txn("both->write", 1'b1, 1'b1, 32'h0000_2468, l0, 0, 1'b0,
               32'h0000_2460, l0, model_lat(0));
        do_txn("both->read", 1'b0, 1'b1, 32'h0000_2468, l1, 1, 1'b0,
               32'h0000_2460, l1, model_lat(1));
        idle(2, "both quiet");

        // Back-to-back: write requested in the cycle right after the read's DONE.
        l0 = rand256();
        l1 = rand256();
        do_txn("b2b read", 1'b0, 1'b0, 32'h1000_0000, l0, 0, 1'b1,
               32'h1000_0000, l0, model_lat(0));
        do_txn("b2b write", 1'b1, 1'b0, 32'h2000_0020, l1, 0, 1'b1,
               32'h2000_0020, l1, model_lat(0));
        idle(2, "b2b quiet");

        // Reset in the middle of a read burst.
        l0 = rand256();
        @(posedge clk); #1;
        bus.line_read_i    = 1'b1;
        bus.line_address_i = 32'h0000_4000;
        bus.burst_resp_i   = 1'b0;
        @(posedge clk); #1;
        bus.burst_resp_i = 1'b1;
        bus.burst_i      = l0[63:0];
        @(posedge clk); #1;
        bus.burst_i      = l0[127:64];
        @(posedge clk); #1;
        bus.burst_resp_i = 1'b0;
        chk("partial gather", 256'(bus.line_o[127:0]), 256'(l0[127:0]));
        #1 rst = 1'b0;
        #1;
        chk("mid reset {resp,rd,wr}", 256'({bus.line_resp_o, bus.burst_read_o, bus.burst_write_o}), 256'(0));
        chk("mid reset line_o", bus.line_o, 256'(0));
        model_line = '0;
        bus.line_read_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        idle(4, "no resp after reset");
        l1 = rand256();
        do_txn("read after reset", 1'b0, 1'b0, 32'h0000_4010, l1, 0, 1'b0,
               32'h0000_4000, l1, model_lat(0));
        idle(1, "after reset quiet");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 16; i++) begin
            w  = 1'($urandom_range(0, 1));
            a0 = $urandom;
            l0 = rand256();
            s  = $urandom_range(0, 3);
            do_txn($sformatf("rnd%0d", i), w, 1'($urandom_range(0, 1)) & w, a0, l0, s, 1'b1,
                   model_addr(a0), l0, model_lat(s));
            if (w) begin
                // A pending read was left asserted; let it run as its own burst.
                if (bus.line_read_i) begin
                    l1 = rand256();
                    do_txn($sformatf("rnd%0d pend", i), 1'b0, 1'b1, a0, l1, 0, 1'b0,
                           model_addr(a0), l1, model_lat(0));
                end
            end
            idle($urandom_range(1, 2), $sformatf("rnd%0d quiet", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Responder for the d_cache physical-memory port. Accepts 256-bit line read/write requests on the pmem_* handshake and converts each one into a fixed-length 64-bit burst toward main memory.
- Sits between the cache/arbiter and the burst main-memory model.
- Gathers read beats into a full line and scatters write lines into beats. Asserts a single-cycle line response when the burst completes.

Parameters:
- s_offset, 5, line offset bits; line is 2**s_offset bytes.
- s_line, 256, line width in bits (8*2**s_offset).
- s_burst, 64, burst beat width in bits.
- num_beats, s_line/s_burst (4), beats per line; must be a power of two ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- line_address_i  in  32  line request address from cache (pmem_address).
- line_i  in  s_line  write line from cache (pmem_wdata).
- line_read_i  in  1  line read request (pmem_read).
- line_write_i  in  1  line write request (pmem_write).
- line_o  out  s_line  assembled read line (pmem_rdata).
- line_resp_o  out  1  line response, one-cycle pulse (pmem_resp).
- burst_address_o  out  32  memory burst address, low s_offset bits forced 0.
- burst_o  out  s_burst  write beat data to memory.
- burst_read_o  out  1  memory read request, held for whole burst.
- burst_write_o  out  1  memory write request, held for whole burst.
- burst_i  in  s_burst  read beat data from memory.
- burst_resp_i  in  1  memory beat acknowledge, one per beat.

Behaviour:
- Reset (rst=0, async):
  - state IDLE, beat counter 0.
  - line_o=0, line_resp_o=0, burst_read_o=0, burst_write_o=0, burst_o=0, burst_address_o=0.
  - Takes effect immediately, including mid-burst. The in-flight burst is abandoned, and no line_resp_o is ever produced for it.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - line_write_i=1 → latch address (low s_offset bits cleared) and line_i into the write buffer; cnt=0; go to WRITE.
  - Else line_read_i=1 → latch address; cnt=0; go to READ.
  - If both requests are high, write wins. The read stays pending and is served after DONE if still asserted.
- READ:
  - burst_read_o=1 and burst_address_o=latched address throughout.
  - On each burst_resp_i=1, store burst_i into line_o[cnt*s_burst +: s_burst]; cnt++.
  - Beat 0 maps to bits 63:0 (little-endian beat order).
  - When the beat with cnt=num_beats-1 is accepted, go to DONE. burst_read_o drops in the DONE cycle.
- WRITE:
  - burst_write_o=1 throughout; burst_o = buffer[cnt*s_burst +: s_burst] (combinational on cnt).
  - On each burst_resp_i=1, cnt++, so the next beat is presented the following cycle.
  - Last beat accepted → DONE.
- DONE:
  - line_resp_o=1 for exactly one cycle; line_o is valid for reads.
  - Next state is IDLE unconditionally.
- Counter: log2(num_beats) bits; wraps to 0 after the last beat. No explicit clear is needed beyond the IDLE load.
- line_o holds its last assembled value until the next read burst's first beat overwrites it. Write bursts never modify line_o.
- Latency, with memory acking every cycle from the first request cycle: request seen in IDLE at cycle t → beats at t+1..t+4 → line_resp_o at t+5.
- Requester contract: line_read_i/line_write_i are deasserted in the cycle after line_resp_o. The adapter samples requests in IDLE only.
- Requests are ignored in READ, WRITE and DONE.
- Changes to line_address_i or line_i mid-burst have no effect; the latched copies are used.
- burst_resp_i seen in IDLE or DONE is ignored.
- Stalls: burst_resp_i may stay low for any number of cycles. The state, the counter and burst_o are then held.

Test Plan:
- Read, zero-wait memory: line_read_i=1, addr=0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → burst_address_o=0x0000_1220; line_o={0x44..44,0x33..33,0x22..22,0x11..11}; line_resp_o pulses exactly once, 5 cycles after request.
- Write with stalls: line_write_i=1, addr=0x8000_0040, line_i=256'h{D,C,B,A} (64-bit words A..D); memory inserts 2 idle cycles before each ack → burst_o presents A,B,C,D in order, each held until its ack; burst_write_o high continuously; one line_resp_o after the 4th ack; line_o unchanged.
- Simultaneous read_i=1 and write_i=1 in IDLE → WRITE burst first, burst_read_o stays 0; after DONE with read_i still high → READ burst follows.
- Reset mid-read: assert rst=0 after beat 2 → burst_read_o=0 and line_o=0 in the same cycle, no line_resp_o; after release, a new read completes normally with cnt starting at 0.
- Spurious burst_resp_i=1 while IDLE, and request inputs changed mid-burst → no state change, no response, and the beat data/address come from the latched values.
- Back-to-back: a read followed by a write requested in the cycle after DONE → the write buffer is loaded fresh, and line_o keeps the read line.
